data_mem_responder: RTL



---
 rtl/data_mem_responder.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder: program ROM, data RAM and a small I/O page
// with output/input stream FIFOs and a free-running cycle counter.
module data_mem_responder #(
    parameter int PROG_AW = 10,
    parameter int DATA_AW = 12,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        p_addr,
    output logic [23:0]        p,
    input  logic [15:0]        d_addr,
    input  logic [15:0]        w_data,
    input  logic               we,
    output logic [15:0]        r_data,
    input  logic               pl_we,
    input  logic [PROG_AW-1:0] pl_addr,
    input  logic [23:0]        pl_data,
    output logic               out_valid,
    output logic [15:0]        out_data,
    input  logic               out_ready,
    input  logic               in_valid,
    input  logic [15:0]        in_data,
    output logic               in_ready
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;

    logic [23:0] prog [0:(1<<PROG_AW)-1];
    logic [15:0] ram  [0:(1<<DATA_AW)-1];
    logic [15:0] omem [0:DEPTH-1];
    logic [15:0] imem [0:DEPTH-1];

    logic [FIFO_AW-1:0] owp, orp, iwp, irp;
    logic [CW-1:0]      ocnt, icnt;
    logic               ovf;
    logic [15:0]        cyc;
    logic [15:0]        rd_val;

    logic       io_sel;
    logic [7:0] io_reg;
    logic       out_full, out_empty, in_full, in_empty;
    logic       o_push, o_pop, o_keep, o_drop;
    logic       i_push, i_pop;
    logic       stat_clr, cyc_wr;

    assign io_sel = (d_addr[15:8] == 8'hFF);
    assign io_reg = d_addr[7:0];

    assign out_full  = (ocnt == CW'(DEPTH));
    assign out_empty = (ocnt == '0);
    assign in_full   = (icnt == CW'(DEPTH));
    assign in_empty  = (icnt == '0);

    // A push onto a full FIFO survives only if the head leaves this cycle
    assign o_push = we && io_sel && (io_reg == 8'h00);
    assign o_pop  = !out_empty && out_ready;
    assign o_keep = o_push && (!out_full || o_pop);
    assign o_drop = o_push && out_full && !o_pop;

    assign i_push = in_valid && !in_full;
    assign i_pop  = we && io_sel && (io_reg == 8'h02) && !in_empty;

    assign stat_clr = we && io_sel && (io_reg == 8'h03) && w_data[4];
    assign cyc_wr   = we && io_sel && (io_reg == 8'h04);

    assign p = (p_addr[15:PROG_AW] == '0) ? prog[p_addr[PROG_AW-1:0]] : '0;

    assign out_valid = !out_empty;
    assign out_data  = out_empty ? '0 : omem[orp];
    assign in_ready  = !in_full;

    always_comb begin
        rd_val = '0;
        if (!io_sel) begin
            rd_val = ram[d_addr[DATA_AW-1:0]];
        end else begin
            case (io_reg)
                8'h00:   rd_val = {{(16-CW){1'b0}}, ocnt};
                8'h01:   rd_val = in_empty ? '0 : imem[irp];
                8'h03:   rd_val = {11'b0, ovf, !in_empty, in_full,
                                   out_empty, out_full};
                8'h04:   rd_val = cyc;
                default: rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pl_we)
            prog[pl_addr] <= pl_data;
    end

    always_ff @(posedge clk) begin
        if (we && !io_sel)
            ram[d_addr[DATA_AW-1:0]] <= w_data;
    end

    always_ff @(posedge clk) begin
        if (o_keep)
            omem[owp] <= w_data;
        if (i_push)
            imem[iwp] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owp    <= '0;
            orp    <= '0;
            ocnt   <= '0;
            iwp    <= '0;
            irp    <= '0;
            icnt   <= '0;
            ovf    <= 1'b0;
            cyc    <= '0;
            r_data <= '0;
        end else begin
            if (o_keep)
                owp <= owp + 1'b1;
            if (o_pop)
                orp <= orp + 1'b1;
            ocnt <= ocnt + CW'(o_keep) - CW'(o_pop);

            if (i_push)
                iwp <= iwp + 1'b1;
            if (i_pop)
                irp <= irp + 1'b1;
            icnt <= icnt + CW'(i_push) - CW'(i_pop);

            if (o_drop)
                ovf <= 1'b1;
            else if (stat_clr)
                ovf <= 1'b0;

            cyc    <= cyc_wr ? w_data : cyc + 16'd1;
            r_data <= rd_val;
        end
    end

endmodule
